// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one frame-buffer RAM port between display reads and FIFO-buffered writes (define SCALE2X_EN for 2x scan)
module fb_port_arbiter #(
  parameter int bitsPixel = 8,
  parameter int imgWidth  = 320,
  parameter int imgHeight = 240,
  parameter int addrBits  = 17,
  parameter int fifoDepth = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_DV,
  input  logic [bitsPixel-1:0] i_pixel,
  output logic                 o_wr_ready,
  input  logic                 i_rd_req,
  input  logic                 i_frame_start,
  output logic [addrBits-1:0]  o_ram_addr,
  output logic                 o_ram_we,
  output logic [bitsPixel-1:0] o_ram_wdata,
  input  logic [bitsPixel-1:0] i_ram_rdata,
  output logic [bitsPixel-1:0] o_pixel,
  output logic                 o_pixel_valid,
  output logic                 o_overflow,
  output logic                 o_frame_done
);
`ifdef SCALE2X_EN
  localparam int SX = 2;
`else
  localparam int SX = 1;
`endif
  localparam int XN = SX * imgWidth;
  localparam int YN = SX * imgHeight;
  localparam int XW = XN > 1 ? $clog2(XN) : 1;
  localparam int YW = YN > 1 ? $clog2(YN) : 1;
  localparam int PW = fifoDepth > 1 ? $clog2(fifoDepth) : 1;
  localparam logic [addrBits-1:0] LAST_A = addrBits'(imgWidth * imgHeight - 1);
  logic [bitsPixel-1:0] fifo [fifoDepth];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [XW-1:0] out_x, cx, nx;
  logic [YW-1:0] out_y, cy, ny;
  logic [addrBits-1:0] row_base, rb, nrb, src_addr, wr_addr;
  logic rd_ram, push, pop, x_last, y_last;
  logic v1, v2, r1, r2;
  logic [bitsPixel-1:0] held;
  always_comb begin
    o_wr_ready = cnt < (PW+1)'(fifoDepth);
    push = i_DV && o_wr_ready;
    cx = i_frame_start ? '0 : out_x;
    cy = i_frame_start ? '0 : out_y;
    rb = i_frame_start ? '0 : row_base;
    src_addr = rb + addrBits'(cx >> (SX - 1));
    rd_ram = i_rd_req && (SX == 1 || !cx[0]);
    pop = !rd_ram && cnt != '0;
    x_last = cx == XW'(XN - 1);
    y_last = cy == YW'(YN - 1);
    nx = x_last ? '0 : cx + 1'b1;
    ny = !x_last ? cy : y_last ? '0 : cy + 1'b1;
    nrb = !x_last ? rb : y_last ? '0 : (SX == 1 || cy[0]) ? rb + addrBits'(imgWidth) : rb;
  end
  always_ff @(posedge clk)
    if (push) fifo[wp] <= i_pixel;
  // odd columns in 2x mode reuse the pixel held from the preceding even-column read
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {wp, rp, cnt, out_x, out_y, row_base, wr_addr} <= '0;
      {o_ram_addr, o_ram_we, o_ram_wdata, o_pixel, o_pixel_valid, o_overflow, o_frame_done} <= '0;
      {v1, v2, r1, r2, held} <= '0;
    end else begin
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      o_overflow <= o_overflow || (i_DV && !o_wr_ready);
      out_x <= i_rd_req ? nx : cx;
      out_y <= i_rd_req ? ny : cy;
      row_base <= i_rd_req ? nrb : rb;
      o_ram_we <= pop;
      o_ram_addr <= rd_ram ? src_addr : pop ? wr_addr : o_ram_addr;
      o_ram_wdata <= pop ? fifo[rp] : o_ram_wdata;
      o_frame_done <= pop && wr_addr == LAST_A;
      wr_addr <= !pop ? wr_addr : wr_addr == LAST_A ? '0 : wr_addr + 1'b1;
      v1 <= i_rd_req;
      r1 <= rd_ram;
      v2 <= v1;
      r2 <= r1;
      o_pixel_valid <= v2;
      o_pixel <= v2 ? (r2 ? i_ram_rdata : held) : o_pixel;
      held <= r2 ? i_ram_rdata : held;
    end
endmodule
